quad_encoder_array: RTL and testbench

//  N_CH-channel quadrature decoder for the minibot wheel/odometry encoders; next-generation encoder block.
//  Per channel: synchronise A/B to clk, glitch-filter, decode x1/x2/x4, accumulate a signed step count

---
 rtl/quad_encoder_array.sv | 238 +++++++++++++++++++++++
 tb/tb_quad_encoder_array.sv | 262 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/quad_encoder_array.sv
// ============================================================================
// quad_encoder_array
// ----------------------------------------------------------------------------
// Multi-channel quadrature decoder for the wheel/odometry encoders. Each
// channel synchronises its A/B pins into clk, glitch-filters them, decodes
// x1/x2/x4 steps and accumulates a signed, saturating count over a fixed
// window of PERIOD clk cycles. At the end of every window it publishes
// pulse = clamp(OFFSET + count, 0, 2^W-1). Illegal transitions (A and B
// changing in the same filtered cycle) raise a sticky per-channel error flag.
//
// Ports
//   clk           in   1         system clock
//   tickReset     in   1         asynchronous, active-high reset
//   A, B          in   N_CH      encoder phases (asynchronous to clk)
//   mode          in   2         0: x1, 1: x2, 2/3: x4
//   err_clr       in   1         synchronous clear of all err bits
//   pulse         out  N_CH*W    channel c at [c*W +: W], last window result
//   sample_valid  out  1         one-cycle strobe, pulse updated this cycle
//   err           out  N_CH      sticky illegal-transition flags
// ============================================================================
module quad_encoder_array #(
    parameter int N_CH     = 2,
    parameter int W        = 32,
    parameter int PERIOD   = 50000,
    parameter int OFFSET   = 1023,
    parameter int FILT_LEN = 3
) (
    input  logic              clk,
    input  logic              tickReset,
    input  logic [N_CH-1:0]   A,
    input  logic [N_CH-1:0]   B,
    input  logic [1:0]        mode,
    input  logic              err_clr,
    output logic [N_CH*W-1:0] pulse,
    output logic              sample_valid,
    output logic [N_CH-1:0]   err
);

    localparam int CW = (PERIOD > 1) ? $clog2(PERIOD) : 1;
    localparam int FW = (FILT_LEN > 0) ? $clog2(FILT_LEN + 1) : 1;
    localparam logic [CW-1:0]  WIN_LAST   = CW'(PERIOD - 1);
    localparam logic [W+1:0]   OFFSET_X   = (W+2)'(OFFSET);
    localparam logic [W-1:0]   OFFSET_W   = W'(OFFSET);
    localparam logic [W-1:0]   ACC_MAX    = {1'b0, {(W-1){1'b1}}};
    localparam logic [W-1:0]   ACC_MIN    = {1'b1, {(W-1){1'b0}}};

    // Reset: asserts immediately, releases two clk edges after tickReset drops.
    logic [1:0] r_rst_sync;
    logic       w_rst;

    // Reset synchroniser: async assert, synchronous release.
    always_ff @(posedge clk or posedge tickReset) begin
        if (tickReset) begin
            r_rst_sync <= 2'b11;
        end else begin
            r_rst_sync <= {r_rst_sync[0], 1'b0};
        end
    end

    assign w_rst = r_rst_sync[1];

    // ------------------------------------------------------------------
    // Window counter shared by all channels
    // ------------------------------------------------------------------
    logic [CW-1:0] r_win_cnt;
    logic          r_sample_valid;
    logic          w_win_last;

    assign w_win_last = (r_win_cnt == WIN_LAST);

    // Window counter and the strobe that follows each window close.
    always_ff @(posedge clk or posedge w_rst) begin
        if (w_rst) begin
            r_win_cnt      <= '0;
            r_sample_valid <= 1'b0;
        end else begin
            if (w_win_last) begin
                r_win_cnt <= '0;
            end else begin
                r_win_cnt <= r_win_cnt + CW'(1);
            end
            r_sample_valid <= w_win_last;
        end
    end

    assign sample_valid = r_sample_valid;

    // ------------------------------------------------------------------
    // Per-channel datapath
    // ------------------------------------------------------------------
    for (genvar c = 0; c < N_CH; c++) begin : g_ch
        logic [1:0]   r_s1;        // {A,B} first sync stage
        logic [1:0]   r_s2;        // {A,B} second sync stage
        logic [1:0]   w_cur;       // filtered {A,B}
        logic [1:0]   r_prev;      // filtered {A,B} one cycle ago
        logic [W-1:0] r_acc;
        logic [W-1:0] r_pulse;
        logic         r_err;

        logic         w_fwd;
        logic         w_rev;
        logic         w_illegal;
        logic         w_count;
        logic [1:0]   w_step;      // two's complement -1/0/+1
        logic [W:0]   w_acc_sum;
        logic [W-1:0] w_acc_sat;
        logic [W+1:0] w_pulse_sum;
        logic [W-1:0] w_pulse_clamped;

        // Two-flop synchroniser for the asynchronous encoder pins.
        always_ff @(posedge clk or posedge w_rst) begin
            if (w_rst) begin
                r_s1 <= 2'b00;
                r_s2 <= 2'b00;
            end else begin
                r_s1 <= {A[c], B[c]};
                r_s2 <= r_s1;
            end
        end

        if (FILT_LEN == 0) begin : g_nofilt
            assign w_cur = r_s2;
        end else begin : g_filt
            for (genvar b = 0; b < 2; b++) begin : g_bit
                logic          r_filt;
                logic [FW-1:0] r_stab;

                // Accept a new level only after it has held FILT_LEN cycles;
                // any return to the accepted level restarts the count.
                always_ff @(posedge clk or posedge w_rst) begin
                    if (w_rst) begin
                        r_filt <= 1'b0;
                        r_stab <= '0;
                    end else if (r_s2[b] == r_filt) begin
                        r_filt <= r_filt;
                        r_stab <= '0;
                    end else if (r_stab == FW'(FILT_LEN - 1)) begin
                        r_filt <= r_s2[b];
                        r_stab <= '0;
                    end else begin
                        r_filt <= r_filt;
                        r_stab <= r_stab + FW'(1);
                    end
                end

                assign w_cur[b] = r_filt;
            end
        end

        // Step decode: direction from the AB transition, gated by mode.
        always_comb begin
            w_fwd   = 1'b0;
            w_rev   = 1'b0;
            w_count = 1'b0;
            w_step  = 2'b00;
            // forward cycle 00->10->11->01->00 ({A,B})
            case ({r_prev, w_cur})
                4'b0010, 4'b1011, 4'b1101, 4'b0100: w_fwd = 1'b1;
                4'b1000, 4'b1110, 4'b0111, 4'b0001: w_rev = 1'b1;
                default: begin
                    w_fwd = 1'b0;
                    w_rev = 1'b0;
                end
            endcase
            case (mode)
                2'd0:    w_count = ~r_prev[1] & w_cur[1];   // A rise only
                2'd1:    w_count = r_prev[1] ^ w_cur[1];    // any A edge
                default: w_count = 1'b1;                    // every edge
            endcase
            if (w_count && w_fwd) begin
                w_step = 2'b01;
            end else if (w_count && w_rev) begin
                w_step = 2'b11;
            end else begin
                w_step = 2'b00;
            end
        end

        assign w_illegal = ((r_prev ^ w_cur) == 2'b11);

        // Saturating accumulate and the clamped window result.
        always_comb begin
            w_acc_sum   = {r_acc[W-1], r_acc} + {{(W-1){w_step[1]}}, w_step};
            w_acc_sat   = w_acc_sum[W-1:0];
            w_pulse_sum = OFFSET_X + {{2{r_acc[W-1]}}, r_acc}
                        + {{W{w_step[1]}}, w_step};
            w_pulse_clamped = w_pulse_sum[W-1:0];
            // top two bits disagree -> the signed sum left the W-bit range
            if (w_acc_sum[W] != w_acc_sum[W-1]) begin
                w_acc_sat = w_acc_sum[W] ? ACC_MIN : ACC_MAX;
            end else begin
                w_acc_sat = w_acc_sum[W-1:0];
            end
            if (w_pulse_sum[W+1]) begin
                w_pulse_clamped = '0;
            end else if (w_pulse_sum[W]) begin
                w_pulse_clamped = {W{1'b1}};
            end else begin
                w_pulse_clamped = w_pulse_sum[W-1:0];
            end
        end

        // Accumulator, published result and previous-AB history.
        always_ff @(posedge clk or posedge w_rst) begin
            if (w_rst) begin
                r_prev  <= 2'b00;
                r_acc   <= '0;
                r_pulse <= OFFSET_W;
            end else begin
                r_prev <= w_cur;
                if (w_win_last) begin
                    r_acc   <= '0;
                    r_pulse <= w_pulse_clamped;
                end else begin
                    r_acc   <= w_acc_sat;
                    r_pulse <= r_pulse;
                end
            end
        end

        // Sticky error flag; a new illegal event beats a same-cycle clear.
        always_ff @(posedge clk or posedge w_rst) begin
            if (w_rst) begin
                r_err <= 1'b0;
            end else if (w_illegal) begin
                r_err <= 1'b1;
            end else if (err_clr) begin
                r_err <= 1'b0;
            end else begin
                r_err <= r_err;
            end
        end

        assign pulse[c*W +: W] = r_pulse;
        assign err[c]          = r_err;
    end

endmodule

// File: tb/tb_quad_encoder_array.sv
module tb_quad_encoder_array;

    localparam int N_CH     = 2;
    localparam int W        = 16;
    localparam int PERIOD   = 100;
    localparam int OFFSET   = 1023;
    localparam int FILT_LEN = 2;

    logic              clk = 1'b0;
    logic              tickReset;
    logic [N_CH-1:0]   a_drv;
    logic [N_CH-1:0]   b_drv;
    logic [1:0]        mode;
    logic              err_clr;
    logic [N_CH*W-1:0] pulse;
    logic              sample_valid;
    logic [N_CH-1:0]   err;

    logic [W-1:0] p0;
    logic [W-1:0] p1;
    assign p0 = pulse[W-1:0];
    assign p1 = pulse[2*W-1:W];

    int total = 0;
    int bad   = 0;

    // reference model: quadrature phase index per channel, expected window count
    int phase [N_CH];
    int expc  [N_CH];

    quad_encoder_array #(
        .N_CH(N_CH), .W(W), .PERIOD(PERIOD), .OFFSET(OFFSET), .FILT_LEN(FILT_LEN)
    ) dut (
        .clk(clk),
        .tickReset(tickReset),
        .A(a_drv),
        .B(b_drv),
        .mode(mode),
        .err_clr(err_clr),
        .pulse(pulse),
        .sample_valid(sample_valid),
        .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
        total++;
        assert (obs === exp_v) else begin
            bad++;
            $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp_v);
        end
    endtask

    // {A,B} for each position of the forward quadrature cycle
    function automatic logic [1:0] ab_of(input int p);
        case (p & 3)
            0:       return 2'b00;
            1:       return 2'b10;
            2:       return 2'b11;
            default: return 2'b01;
        endcase
    endfunction

    // counts contributed by one legal step of direction dir under mode m
    function automatic int count_of(input int m, input logic [1:0] o, input logic [1:0] n,
                                    input int dir);
        if (m >= 2)            return dir;
        if (m == 1)            return (o[1] != n[1]) ? dir : 0;
        return (!o[1] && n[1]) ? dir : 0;
    endfunction

    task automatic move(input int c, input int dir);
        logic [1:0] o;
        logic [1:0] n;
        o        = ab_of(phase[c]);
        phase[c] = (phase[c] + dir + 4) % 4;
        n        = ab_of(phase[c]);
        expc[c]  = expc[c] + count_of(int'(mode), o, n, dir);
        a_drv[c] = n[1];
        b_drv[c] = n[0];
    endtask

    // both phases flip at once: illegal, moves two positions round the cycle
    task automatic flip_both(input int c);
        logic [1:0] n;
        phase[c] = (phase[c] + 2) % 4;
        n        = ab_of(phase[c]);
        a_drv[c] = n[1];
        b_drv[c] = n[0];
    endtask

    // leaves the bench on the negedge right after a window close
    task automatic wait_sv(input string tag);
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 300);
        check(tag, 32'(sample_valid), 32'd1);
    endtask

    task automatic run_window(input string tag, input int n0, input int n1, input int sp,
                              input int d0, input int d1);
        int nmax;
        expc[0] = 0;
        expc[1] = 0;
        nmax = (n0 > n1) ? n0 : n1;
        for (int k = 0; k < nmax; k++) begin
            if (k < n0) move(0, (d0 != 0) ? d0 : (($urandom_range(0, 1) == 0) ? 1 : -1));
            if (k < n1) move(1, (d1 != 0) ? d1 : (($urandom_range(0, 1) == 0) ? 1 : -1));
            repeat (sp) @(negedge clk);
        end
        wait_sv({tag, "_sv"});
        check({tag, "_p0"}, 32'(p0), 32'(OFFSET + expc[0]));
        check({tag, "_p1"}, 32'(p1), 32'(OFFSET + expc[1]));
    endtask

    // release reset on a negedge and time the first window close
    task automatic release_and_check(input string tag);
        int n;
        @(negedge clk);
        tickReset = 1'b0;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!sample_valid && n < 300);
        check({tag, "_first_win"}, 32'((n >= PERIOD) && (n <= PERIOD + 3)), 32'd1);
        check({tag, "_p0"}, 32'(p0), 32'(OFFSET));
        check({tag, "_p1"}, 32'(p1), 32'(OFFSET));
    endtask

    initial begin
        tickReset = 1'b1;
        a_drv     = '0;
        b_drv     = '0;
        mode      = 2'd2;
        err_clr   = 1'b0;
        phase[0]  = 0;
        phase[1]  = 0;
        expc[0]   = 0;
        expc[1]   = 0;

        // reset state
        #12;
        check("rst_p0", 32'(p0), 32'(OFFSET));
        check("rst_p1", 32'(p1), 32'(OFFSET));
        check("rst_sv", 32'(sample_valid), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        release_and_check("rel1");

        // x4 / x2 / x1 forward, x4 reverse, 40 edges in one window on ch0
        mode = 2'd2;
        run_window("x4_fwd", 40, 0, 2, 1, 0);
        mode = 2'd1;
        run_window("x2_fwd", 40, 0, 2, 1, 0);
        mode = 2'd0;
        run_window("x1_fwd", 40, 0, 2, 1, 0);
        mode = 2'd3;
        run_window("x4_rev", 40, 0, 2, -1, 0);
        mode = 2'd2;
        run_window("ch1_rev", 0, 12, 3, 0, -1);

        // one-cycle glitch on A must be rejected by the filter
        a_drv[0] = ~a_drv[0];
        @(negedge clk);
        a_drv[0] = ~a_drv[0];
        wait_sv("glitch_sv");
        check("glitch_p0", 32'(p0), 32'(OFFSET));
        check("glitch_err", 32'(err), 32'd0);

        // illegal transition: err set, count unchanged
        flip_both(0);
        wait_sv("ill_sv");
        check("ill_p0", 32'(p0), 32'(OFFSET));
        check("ill_err", 32'(err), 32'd1);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr", 32'(err), 32'd0);
        wait_sv("errclr_sv");

        // err_clr on the very cycle an illegal step is decoded: set wins
        flip_both(0);
        repeat (4) @(negedge clk);
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("set_wins", 32'(err), 32'd1);
        wait_sv("setw_sv");
        check("setw_p0", 32'(p0), 32'(OFFSET));
        err_clr = 1'b1;
        @(negedge clk);
        err_clr = 1'b0;
        check("errclr2", 32'(err), 32'd0);
        wait_sv("errclr2_sv");

        // strobe is one cycle wide and recurs every PERIOD cycles
        begin
            int n;
            @(negedge clk);
            check("sv_width", 32'(sample_valid), 32'd0);
            n = 1;
            while (!sample_valid && n < 300) begin
                @(negedge clk);
                n++;
            end
            check("sv_period", 32'(n), 32'(PERIOD));
        end

        // step decoded on the closing edge belongs to the closing window
        mode = 2'd2;
        repeat (95) @(negedge clk);
        move(0, 1);
        wait_sv("last_sv");
        check("last_in", 32'(p0), 32'(OFFSET + 1));
        // one cycle later it belongs to the next window
        repeat (96) @(negedge clk);
        move(0, 1);
        wait_sv("next_sv");
        check("next_out", 32'(p0), 32'(OFFSET));
        wait_sv("next2_sv");
        check("next_in", 32'(p0), 32'(OFFSET + 1));

        // randomized windows, random mode per window
        for (int w = 0; w < 8; w++) begin
            mode = 2'($urandom_range(0, 3));
            run_window($sformatf("rnd%0d", w), int'($urandom_range(0, 30)),
                       int'($urandom_range(0, 30)), 3, 0, 0);
        end

        // reset mid-window with a non-idle state
        mode = 2'd2;
        run_window("pre_rst", 10, 0, 2, 1, 0);
        flip_both(1);
        repeat (6) @(negedge clk);
        check("pre_rst_err", 32'(err), 32'd2);
        for (int k = 0; k < 5; k++) begin
            move(0, 1);
            repeat (2) @(negedge clk);
        end
        #2;
        tickReset = 1'b1;
        #1;
        check("mid_rst_p0", 32'(p0), 32'(OFFSET));
        check("mid_rst_p1", 32'(p1), 32'(OFFSET));
        check("mid_rst_sv", 32'(sample_valid), 32'd0);
        check("mid_rst_err", 32'(err), 32'd0);
        a_drv    = '0;
        b_drv    = '0;
        phase[0] = 0;
        phase[1] = 0;
        release_and_check("rel2");
        run_window("post_rst", 20, 20, 3, 0, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
